// File: rtl/rv32_e_div_if.sv
// rv32_e_div_if: issue/complete bundle between the execute stage and the divider.
// The pipeline side is master, the divider is slave.
interface rv32_e_div_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) ();
   logic             start_i;
   logic [1:0]       op_i;
   logic [XLEN-1:0]  src_a_i;
   logic [XLEN-1:0]  src_b_i;
   logic [TAG_W-1:0] tag_i;
   logic             flush_i;
   logic             busy_o;
   logic             valid_o;
   logic [XLEN-1:0]  result_o;
   logic [TAG_W-1:0] tag_o;

   modport master (
      output start_i, op_i, src_a_i, src_b_i, tag_i, flush_i,
      input  busy_o, valid_o, result_o, tag_o
   );

   modport slave (
      input  start_i, op_i, src_a_i, src_b_i, tag_i, flush_i,
      output busy_o, valid_o, result_o, tag_o
   );
endinterface

// File: rtl/rv32_e_div.sv
// rv32_e_div: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Define RV32_DIV_EARLY_OUT_EN to skip the dividend's leading zero bits.
module rv32_e_div #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input logic         clk_i,
   input logic         rst_ni,
   rv32_e_div_if.slave bus
);
   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state_q, state_d;
   logic             is_rem_q, is_rem_d;
   logic             sa_q, sa_d;
   logic             sb_q, sb_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [TAG_W-1:0] tout_q, tout_d;
   logic [XLEN-1:0]  acc_q, acc_d;
   logic [XLEN-1:0]  quo_q, quo_d;
   logic [XLEN-1:0]  dvs_q, dvs_d;
   logic [XLEN-1:0]  res_q, res_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic            accept, sgn, a_neg, b_neg;
   logic            div_zero, ovf, zero_dvd, fast;
   logic [XLEN-1:0] a_mag, b_mag, dvd_init, fast_res;
   logic [CW-1:0]   iters;
   logic [XLEN:0]   acc_sh;
   logic            ge;
   logic [XLEN-1:0] acc_nx, quo_nx, q_fix, r_fix, fix;

   assign accept   = bus.start_i && !bus.flush_i;
   assign sgn      = !bus.op_i[0];
   assign a_neg    = sgn && bus.src_a_i[XLEN-1];
   assign b_neg    = sgn && bus.src_b_i[XLEN-1];
   assign a_mag    = a_neg ? -bus.src_a_i : bus.src_a_i;
   assign b_mag    = b_neg ? -bus.src_b_i : bus.src_b_i;
   assign div_zero = bus.src_b_i == '0;
   assign ovf      = sgn && bus.src_a_i == MIN
                     && bus.src_b_i == '1;
   assign fast     = div_zero || ovf || zero_dvd;

`ifdef RV32_DIV_EARLY_OUT_EN
   logic [CW-1:0] k;

   always_comb begin
      k = '0;
      for (int i = 0; i < XLEN; i++)
         if (a_mag[i]) k = CW'(i + 1);
   end

   // Align the top set bit with the MSB so only k steps are needed.
   assign dvd_init = a_mag << (CW'(XLEN) - k);
   assign iters    = k;
   assign zero_dvd = k == '0;
`else
   assign dvd_init = a_mag;
   assign iters    = CW'(XLEN);
   assign zero_dvd = 1'b0;
`endif

   always_comb begin
      fast_res = '0;
      unique case (1'b1)
         div_zero: fast_res = bus.op_i[1] ? bus.src_a_i : '1;
         ovf:      fast_res = bus.op_i[1] ? '0 : MIN;
         default:  fast_res = '0;
      endcase
   end

   // Low XLEN bits of the 33-bit difference equal the truncated subtraction.
   assign acc_sh = {acc_q, quo_q[XLEN-1]};
   assign ge     = acc_sh >= {1'b0, dvs_q};
   assign acc_nx = ge ? acc_sh[XLEN-1:0] - dvs_q
                      : acc_sh[XLEN-1:0];
   assign quo_nx = {quo_q[XLEN-2:0], ge};
   assign q_fix  = (sa_q ^ sb_q) ? -quo_nx : quo_nx;
   assign r_fix  = sa_q ? -acc_nx : acc_nx;
   assign fix    = is_rem_q ? r_fix : q_fix;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:
            if (accept) state_d = fast ? DONE : CALC;
         CALC:
            if (bus.flush_i)            state_d = IDLE;
            else if (cnt_q == CW'(1))   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.busy_o   = state_q != IDLE;
      bus.valid_o  = state_q == DONE && !bus.flush_i;
      bus.result_o = res_q;
      bus.tag_o    = tout_q;
   end

   always_comb begin
      is_rem_d = is_rem_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      tag_d    = tag_q;
      tout_d   = tout_q;
      acc_d    = acc_q;
      quo_d    = quo_q;
      dvs_d    = dvs_q;
      res_d    = res_q;
      cnt_d    = cnt_q;
      unique case (state_q)
         IDLE: if (accept) begin
            is_rem_d = bus.op_i[1];
            sa_d     = a_neg;
            sb_d     = b_neg;
            tag_d    = bus.tag_i;
            dvs_d    = b_mag;
            acc_d    = '0;
            quo_d    = dvd_init;
            cnt_d    = iters;
            if (fast) begin
               res_d  = fast_res;
               tout_d = bus.tag_i;
            end
         end
         CALC: if (!bus.flush_i) begin
            acc_d = acc_nx;
            quo_d = quo_nx;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               res_d  = fix;
               tout_d = tag_q;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         is_rem_q <= 1'b0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         tag_q    <= '0;
         tout_q   <= '0;
         acc_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         res_q    <= '0;
         cnt_q    <= '0;
      end else begin
         is_rem_q <= is_rem_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         tag_q    <= tag_d;
         tout_q   <= tout_d;
         acc_q    <= acc_d;
         quo_q    <= quo_d;
         dvs_q    <= dvs_d;
         res_q    <= res_d;
         cnt_q    <= cnt_d;
      end
   end
endmodule
